// File: rtl/cv32e40x_pma_filter.sv
// +--------------------------------------------------------------------------+
// | cv32e40x_pma_filter: PMA region lookup that blocks illegal core requests  |
// | and returns ordered error responses.                          Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

package cv32e40x_pma_pkg;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        atomic;
  } pma_region_t;

  // Used when regions are configured but none matches.
  parameter pma_region_t PMA_R_DEFAULT = '{
    word_addr_low  : 32'h0000_0000,
    word_addr_high : 32'h0000_0000,
    main           : 1'b0,
    bufferable     : 1'b0,
    cacheable      : 1'b0,
    atomic         : 1'b0
  };

  // Used when the PMA is deconfigured: everything is main memory.
  parameter pma_region_t NO_PMA_R_DEFAULT = '{
    word_addr_low  : 32'h0000_0000,
    word_addr_high : 32'h0000_0000,
    main           : 1'b1,
    bufferable     : 1'b0,
    cacheable      : 1'b0,
    atomic         : 1'b1
  };

endpackage

module cv32e40x_pma_filter
  import cv32e40x_pma_pkg::*;
#(
  parameter bit          A_EXT                            = 1'b0,
  parameter int          PMA_NUM_REGIONS                  = 0,
  parameter pma_region_t PMA_CFG [PMA_NUM_REGIONS-1:0]    = '{default: PMA_R_DEFAULT},
  parameter int          MAX_OUTSTANDING                  = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        core_req_valid_i,
  output logic        core_req_ready_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_instr_i,
  input  logic        core_atomic_i,
  input  logic        core_misaligned_i,
  input  logic        core_we_i,

  output logic        core_resp_valid_o,
  output logic        core_resp_pma_err_o,

  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_bufferable_o,
  output logic        bus_cacheable_o,

  input  logic        bus_resp_valid_i
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             attr_main;
  logic             attr_bufferable;
  logic             attr_cacheable;
  logic             attr_atomic;
  logic             pma_err;

  logic             resp_eff;
  logic             bus_hs;
  logic             cnt_room;
  logic [CNT_W-1:0] cnt_after_resp;

  // ------------------------------------------------------------------------
  // Region lookup
  // ------------------------------------------------------------------------
  generate
    if (PMA_NUM_REGIONS == 0) begin : g_no_pma
      always_comb begin
        attr_main       = NO_PMA_R_DEFAULT.main;
        attr_bufferable = NO_PMA_R_DEFAULT.bufferable;
        attr_cacheable  = NO_PMA_R_DEFAULT.cacheable;
        attr_atomic     = NO_PMA_R_DEFAULT.atomic;
      end
    end else begin : g_pma
      logic [31:0] word_addr;

      assign word_addr = {2'b00, core_addr_i[31:2]};

      // Scan from the highest index down so the lowest matching index wins.
      always_comb begin
        attr_main       = PMA_R_DEFAULT.main;
        attr_bufferable = PMA_R_DEFAULT.bufferable;
        attr_cacheable  = PMA_R_DEFAULT.cacheable;
        attr_atomic     = PMA_R_DEFAULT.atomic;
        for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
          if ((word_addr >= PMA_CFG[i].word_addr_low) &&
              (word_addr <  PMA_CFG[i].word_addr_high)) begin
            attr_main       = PMA_CFG[i].main;
            attr_bufferable = PMA_CFG[i].bufferable;
            attr_cacheable  = PMA_CFG[i].cacheable;
            attr_atomic     = PMA_CFG[i].atomic;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pma_err = (core_atomic_i     && !(A_EXT && attr_atomic)) ||
              (core_instr_i      && !attr_main)              ||
              (core_misaligned_i && !attr_main);
  end

  assign bus_addr_o       = core_addr_i;
  assign bus_bufferable_o = attr_bufferable && !core_instr_i && !core_atomic_i && core_we_i;
  assign bus_cacheable_o  = attr_cacheable;

  // ------------------------------------------------------------------------
  // Outstanding transaction counter
  // ------------------------------------------------------------------------
  // A response with nothing outstanding is dropped so the counter cannot wrap.
  assign resp_eff       = bus_resp_valid_i && (cnt_q != '0);
  assign bus_hs         = bus_req_valid_o && bus_req_ready_i;
  assign cnt_room       = (cnt_q < CNT_MAX);
  assign cnt_after_resp = resp_eff ? (cnt_q - CNT_ONE) : cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bus_hs && !resp_eff) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!bus_hs && resp_eff) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_comb begin
    state_d             = state_q;
    core_req_ready_o    = 1'b0;
    bus_req_valid_o     = 1'b0;
    core_resp_valid_o   = 1'b0;
    core_resp_pma_err_o = 1'b0;

    case (state_q)
      IDLE: begin
        core_resp_valid_o = bus_resp_valid_i;
        if (pma_err) begin
          // Blocked requests never reach the bus, so they are taken even when full.
          core_req_ready_o = 1'b1;
          if (core_req_valid_i) begin
            state_d = (cnt_after_resp == '0) ? RESPOND : WAIT;
          end
        end else begin
          bus_req_valid_o  = core_req_valid_i && cnt_room;
          core_req_ready_o = bus_req_ready_i  && cnt_room;
        end
      end

      WAIT: begin
        core_resp_valid_o = bus_resp_valid_i;
        if (cnt_after_resp == '0) begin
          state_d = RESPOND;
        end
      end

      RESPOND: begin
        core_resp_valid_o   = 1'b1;
        core_resp_pma_err_o = 1'b1;
        state_d             = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep handshake and response outputs quiet while reset is applied.
    if (rst) begin
      core_req_ready_o    = 1'b0;
      bus_req_valid_o     = 1'b0;
      core_resp_valid_o   = 1'b0;
      core_resp_pma_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_spurious_resp : assert property (@(posedge clk) disable iff (rst)
    !(bus_resp_valid_i && (cnt_q == '0)));

  a_cnt_bounded : assert property (@(posedge clk) disable iff (rst)
    (cnt_q <= CNT_MAX));

  a_respond_one_cycle : assert property (@(posedge clk) disable iff (rst)
    (state_q == RESPOND) |=> (state_q == IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_pma_filter.sv
// Self-checking bench for cv32e40x_pma_filter: directed scenarios followed by
// random traffic, all checked against a response-token queue model.
`default_nettype none

module tb_cv32e40x_pma_filter;
  import cv32e40x_pma_pkg::*;

  localparam int MAX_OUT = 2;

  localparam pma_region_t R0 = '{
    word_addr_low : 32'h0000_0000, word_addr_high : 32'h0400_0000,
    main : 1'b1, bufferable : 1'b0, cacheable : 1'b1, atomic : 1'b0
  };
  localparam pma_region_t R1 = '{
    word_addr_low : 32'h0400_0000, word_addr_high : 32'h0800_0000,
    main : 1'b0, bufferable : 1'b1, cacheable : 1'b0, atomic : 1'b0
  };
  localparam pma_region_t CFG [1:0] = '{R1, R0};

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid_i;
  logic        core_req_ready_o;
  logic [31:0] core_addr_i;
  logic        core_instr_i;
  logic        core_atomic_i;
  logic        core_misaligned_i;
  logic        core_we_i;
  logic        core_resp_valid_o;
  logic        core_resp_pma_err_o;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_bufferable_o;
  logic        bus_cacheable_o;
  logic        bus_resp_valid_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected response tokens in order: 0 = bus response, 1 = PMA error.
  int q[$];

  cv32e40x_pma_filter #(
    .A_EXT           (1'b0),
    .PMA_NUM_REGIONS (2),
    .PMA_CFG         (CFG),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .core_req_valid_i    (core_req_valid_i),
    .core_req_ready_o    (core_req_ready_o),
    .core_addr_i         (core_addr_i),
    .core_instr_i        (core_instr_i),
    .core_atomic_i       (core_atomic_i),
    .core_misaligned_i   (core_misaligned_i),
    .core_we_i           (core_we_i),
    .core_resp_valid_o   (core_resp_valid_o),
    .core_resp_pma_err_o (core_resp_pma_err_o),
    .bus_req_valid_o     (bus_req_valid_o),
    .bus_req_ready_i     (bus_req_ready_i),
    .bus_addr_o          (bus_addr_o),
    .bus_bufferable_o    (bus_bufferable_o),
    .bus_cacheable_o     (bus_cacheable_o),
    .bus_resp_valid_i    (bus_resp_valid_i)
  );

  always #5 clk = ~clk;

  // Byte-address view of the configured map.
  function automatic bit in_r0(input logic [31:0] a);
    return a < 32'h1000_0000;
  endfunction

  function automatic bit in_r1(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a < 32'h2000_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input bit instr, input bit atom,
                       input bit mis, input bit we, input bit brdy, input bit bresp);
    core_req_valid_i  = v;
    core_addr_i       = a;
    core_instr_i      = instr;
    core_atomic_i     = atom;
    core_misaligned_i = mis;
    core_we_i         = we;
    bus_req_ready_i   = brdy;
    bus_resp_valid_i  = bresp;
  endtask

  // One clock: predict outputs from the token queue, check at negedge, then
  // advance the queue to match what happens at the following posedge.
  task automatic do_cycle();
    bit main_a, err, has_e;
    bit e_rdy, e_bv, e_rv, e_re, e_buf, e_cach;
    int nb;
    main_a = in_r0(core_addr_i);
    // Atomics are never allowed without the A extension.
    err    = core_atomic_i || ((core_instr_i || core_misaligned_i) && !main_a);
    e_buf  = in_r1(core_addr_i) && !core_instr_i && !core_atomic_i && core_we_i;
    e_cach = in_r0(core_addr_i);
    has_e  = 1'b0;
    foreach (q[i]) if (q[i] == 1) has_e = 1'b1;
    nb     = q.size() - (has_e ? 1 : 0);
    e_rdy = 0; e_bv = 0; e_rv = 0; e_re = 0;

    if (rst) begin
      // all handshake/response outputs quiet
    end else if (q.size() > 0 && q[0] == 1) begin
      e_rv = 1; e_re = 1;
    end else if (has_e) begin
      e_rv = bus_resp_valid_i;
    end else begin
      e_rv = bus_resp_valid_i;
      if (err) e_rdy = 1;
      else begin
        e_bv  = core_req_valid_i && (nb < MAX_OUT);
        e_rdy = bus_req_ready_i  && (nb < MAX_OUT);
      end
    end

    @(negedge clk);
    chk("core_req_ready",  {31'b0, core_req_ready_o},    {31'b0, e_rdy});
    chk("bus_req_valid",   {31'b0, bus_req_valid_o},     {31'b0, e_bv});
    chk("core_resp_valid", {31'b0, core_resp_valid_o},   {31'b0, e_rv});
    chk("core_resp_err",   {31'b0, core_resp_pma_err_o}, {31'b0, e_re});
    chk("bus_bufferable",  {31'b0, bus_bufferable_o},    {31'b0, e_buf});
    chk("bus_cacheable",   {31'b0, bus_cacheable_o},     {31'b0, e_cach});
    chk("bus_addr",        bus_addr_o,                   core_addr_i);

    if (rst) begin
      q.delete();
    end else if (q.size() > 0 && q[0] == 1) begin
      void'(q.pop_front());
    end else begin
      if (bus_resp_valid_i && q.size() > 0) void'(q.pop_front());
      if (!has_e) begin
        if (err && core_req_valid_i) q.push_back(1);
        else if (!err && e_bv && bus_req_ready_i) q.push_back(0);
      end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int cls;
    logic [31:0] a;
    bit ok_resp;

    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset with live inputs: outputs must stay quiet, inputs are dropped.
    drive(1, 32'h0000_1000, 0, 0, 0, 0, 1, 1);
    do_cycle();
    drive(1, 32'h1000_0000, 1, 0, 0, 0, 1, 0);
    do_cycle();
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0, 0, 0);
    do_cycle();

    // Legal load to cacheable main memory, response passes through.
    drive(1, 32'h0000_1000, 0, 0, 0, 0, 1, 0);
    do_cycle();
    drive(0, 32'h0000_1000, 0, 0, 0, 0, 1, 1);
    do_cycle();

    // Store to bufferable I/O region.
    drive(1, 32'h1000_0000, 0, 0, 0, 1, 1, 0);
    do_cycle();
    drive(0, 32'h1000_0000, 0, 0, 0, 1, 1, 1);
    do_cycle();

    // Fetch from non-main region with nothing outstanding: error next cycle.
    drive(1, 32'h1000_0000, 1, 0, 0, 0, 1, 0);
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 0);
    do_cycle();
    do_cycle();

    // Fill to MAX_OUTSTANDING, then a legal load stalls.
    drive(1, 32'h0000_0100, 0, 0, 0, 0, 1, 0);
    do_cycle();
    drive(1, 32'h0000_0200, 0, 0, 0, 0, 1, 0);
    do_cycle();
    drive(1, 32'h0000_0300, 0, 0, 0, 0, 1, 0);
    do_cycle();
    do_cycle();

    // Blocked misaligned access is accepted while full, then waits for drain.
    drive(1, 32'h1000_0002, 0, 0, 1, 0, 1, 0);
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 1);
    do_cycle();
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 0);
    do_cycle();
    do_cycle();

    // Atomic to main memory without A extension is blocked.
    drive(1, 32'h0000_0000, 0, 1, 0, 0, 1, 0);
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 0);
    do_cycle();

    // Reset while waiting discards the pending error response.
    drive(1, 32'h0000_0400, 0, 0, 0, 0, 1, 0);
    do_cycle();
    drive(1, 32'h1000_0000, 1, 0, 0, 0, 1, 0);
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 0);
    do_cycle();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    do_cycle();
    do_cycle();

    // Simultaneous bus handshake and bus response keep one outstanding.
    drive(1, 32'h0000_0500, 0, 0, 0, 0, 1, 0);
    do_cycle();
    drive(1, 32'h0000_0600, 0, 0, 0, 0, 1, 1);
    do_cycle();
    drive(1, 32'h2000_0000, 1, 0, 0, 0, 1, 1);
    do_cycle();
    drive(0, 32'h0, 0, 0, 0, 0, 1, 0);
    do_cycle();

    // Unmapped space: loads pass, stores are not bufferable.
    drive(1, 32'h3000_0010, 0, 0, 0, 1, 1, 0);
    do_cycle();
    drive(0, 32'h3000_0010, 0, 0, 0, 1, 1, 1);
    do_cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: a = $urandom_range(0, 32'h0FFF_FFFF);
        1: a = 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
        2: a = 32'h2000_0000 + $urandom_range(0, 32'h5FFF_FFFF);
        default: a = $urandom;
      endcase
      ok_resp = (q.size() > 0) && (q[0] == 0);
      drive($urandom_range(0, 3) != 0, a,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0,
            ok_resp && ($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 99) == 0);
      do_cycle();
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
